activation_search_unit: RTL

ACTIVATION_SEARCH_UNIT -- requirements
Module: activation_search_unit

---
 rtl/activation_pkg.sv | 38 +++
 rtl/activation_lut_rom.sv | 34 +++
 rtl/activation_search_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/activation_pkg.sv
// Shared types and constants for the activation search unit.
// Mode encodings, FSM states, default match tolerance, ROM content generators.
package activation_pkg;

  typedef enum logic [1:0] {
    MODE_SIGMOID = 2'b00,
    MODE_TANH    = 2'b01,
    MODE_RELU    = 2'b10,
    MODE_IDENT   = 2'b11
  } act_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RANGE,
    S_SEARCH,
    S_LOOKUP,
    S_DONE
  } state_e;

  localparam int DIFF_CHECK_DEF = 'h0040;

  // Tag table (XValues): lower half dense negative, a wide gap,
  // then upper half dense non-negative; ascending signed.
  function automatic int xvalue(input int i, input int depth);
    if (i < depth / 2) return i - depth;
    return i - depth / 2;
  endfunction

  // Activation table (SigTanHContent): upper word / lower word.
  function automatic int sig_word(input int i);
    return i * 97 + 'h1000;
  endfunction

  function automatic int tanh_word(input int i);
    return (i * 131) ^ 'h5A5A;
  endfunction

endpackage

// File: rtl/activation_lut_rom.sv
// Tag ROM (two read ports) and activation ROM, combinational reads.
// Ports: tag_addr_a/b -> tag_a/b, act_addr -> act_word {sigmoid, tanh}.
import activation_pkg::*;

module activation_lut_rom #(
  parameter int DATAWIDTH = 16,
  parameter int INWIDTH   = 9,
  parameter int TAG_SHIFT = 6
) (
  input  logic [INWIDTH-1:0]             tag_addr_a,
  input  logic [INWIDTH-1:0]             tag_addr_b,
  input  logic [INWIDTH-1:0]             act_addr,
  output logic [DATAWIDTH-TAG_SHIFT-1:0] tag_a,
  output logic [DATAWIDTH-TAG_SHIFT-1:0] tag_b,
  output logic [2*DATAWIDTH-1:0]         act_word
);

  localparam int DEPTH = 1 << INWIDTH;
  localparam int TW    = DATAWIDTH - TAG_SHIFT;

  logic [TW-1:0]          tag_mem [DEPTH];
  logic [2*DATAWIDTH-1:0] act_mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign tag_mem[g] = TW'(xvalue(g, DEPTH));
    assign act_mem[g] = {DATAWIDTH'(sig_word(g)),
                         DATAWIDTH'(tanh_word(g))};
  end

  assign tag_a    = tag_mem[tag_addr_a];
  assign tag_b    = tag_mem[tag_addr_b];
  assign act_word = act_mem[act_addr];

endmodule

// File: rtl/activation_search_unit.sv
// Activation unit: binary search of sum in tag ROM, then LUT / ReLU / identity.
// Ports: clock, reset_n, in_valid/in_ready/sum/activation_func in,
//        out_valid/out_ready/activation_value/tag_value/tag_index out.
import activation_pkg::*;

module activation_search_unit #(
  parameter int DATAWIDTH  = 16,
  parameter int INWIDTH    = 9,
  parameter int TAG_SHIFT  = 6,
  parameter int DIFF_CHECK = DIFF_CHECK_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] sum,
  input  logic [1:0]           activation_func,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] activation_value,
  output logic [DATAWIDTH-1:0] tag_value,
  output logic [INWIDTH-1:0]   tag_index
);

  localparam int DW = DATAWIDTH;
  localparam int TW = DATAWIDTH - TAG_SHIFT;
  localparam logic [INWIDTH-1:0] LAST = '1;
  localparam logic [INWIDTH-1:0] ONE  = INWIDTH'(1);
  localparam logic [DW:0]        TOL  = (DW + 1)'(DIFF_CHECK);

  state_e state_q, state_d;
  act_mode_e mode_q, mode_d;
  logic signed [DW-1:0] sum_q, sum_d;
  logic [INWIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [INWIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0] act_q, act_d, tv_q, tv_d;
  logic [INWIDTH-1:0] ti_q, ti_d;

  logic [INWIDTH:0]     mid_w;
  logic [INWIDTH-1:0]   mid, nbr;
  logic [INWIDTH-1:0]   addr_a, addr_b;
  logic [TW-1:0]        tag_a, tag_b;
  logic [2*DW-1:0]      act_word;
  logic signed [DW-1:0] sh_a, sh_b;
  logic signed [DW:0]   diff_a, diff_b;
  logic [DW:0]          mag_a, mag_b;
  logic                 hit, up;

  activation_lut_rom #(
    .DATAWIDTH(DATAWIDTH),
    .INWIDTH  (INWIDTH),
    .TAG_SHIFT(TAG_SHIFT)
  ) u_rom (
    .tag_addr_a(addr_a),
    .tag_addr_b(addr_b),
    .act_addr  (idx_q),
    .tag_a     (tag_a),
    .tag_b     (tag_b),
    .act_word  (act_word)
  );

  assign mid_w = ({1'b0, lo_q} + {1'b0, hi_q}) >> 1;
  assign mid   = mid_w[INWIDTH-1:0];

  // Port A: top tag in RANGE, probe in SEARCH, result tag in LOOKUP.
  assign addr_a = (state_q == S_RANGE)  ? LAST :
                  (state_q == S_SEARCH) ? mid  : idx_q;

  assign sh_a   = {tag_a, {TAG_SHIFT{1'b0}}};
  assign diff_a = {sum_q[DW-1], sum_q} - {sh_a[DW-1], sh_a};
  assign mag_a  = diff_a[DW] ? -diff_a : diff_a;
  assign hit    = mag_a <= TOL;
  assign up     = !diff_a[DW];

  // Port B: bottom tag in RANGE; in SEARCH the neighbour on the side
  // the search would move to, so the final nearest pick needs no extra cycle.
  assign nbr    = up ? mid + ONE : mid - ONE;
  assign addr_b = (state_q == S_SEARCH) ? nbr : '0;

  assign sh_b   = {tag_b, {TAG_SHIFT{1'b0}}};
  assign diff_b = {sum_q[DW-1], sum_q} - {sh_b[DW-1], sh_b};
  assign mag_b  = diff_b[DW] ? -diff_b : diff_b;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sum_d   = sum_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    act_d   = act_q;
    tv_d    = tv_q;
    ti_d    = ti_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sum_d   = sum;
          mode_d  = act_mode_e'(activation_func);
          state_d = activation_func[1] ? S_LOOKUP : S_RANGE;
        end
      end
      S_RANGE: begin
        if (sum_q >= sh_a) begin
          idx_d   = LAST;
          state_d = S_LOOKUP;
        end else if (sum_q <= sh_b) begin
          idx_d   = '0;
          state_d = S_LOOKUP;
        end else begin
          lo_d    = '0;
          hi_d    = LAST;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (hit) begin
          idx_d   = mid;
          state_d = S_LOOKUP;
        end else if (up) begin
          if (mid == hi_q) begin
            idx_d   = (mag_a <= mag_b) ? mid : nbr;
            state_d = S_LOOKUP;
          end else begin
            lo_d = mid + ONE;
          end
        end else begin
          if (mid == lo_q) begin
            idx_d   = (mag_b <= mag_a) ? nbr : mid;
            state_d = S_LOOKUP;
          end else begin
            hi_d = mid - ONE;
          end
        end
      end
      S_LOOKUP: begin
        state_d = S_DONE;
        tv_d    = '0;
        ti_d    = '0;
        unique case (1'b1)
          mode_q == MODE_SIGMOID: begin
            act_d = act_word[2*DW-1:DW];
            tv_d  = sh_a;
            ti_d  = idx_q;
          end
          mode_q == MODE_TANH: begin
            act_d = act_word[DW-1:0];
            tv_d  = sh_a;
            ti_d  = idx_q;
          end
          mode_q == MODE_RELU: begin
            act_d = sum_q[DW-1] ? '0 : sum_q;
          end
          default: begin
            act_d = sum_q;
          end
        endcase
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SIGMOID;
      sum_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      tv_q    <= '0;
      ti_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sum_q   <= sum_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      tv_q    <= tv_d;
      ti_q    <= ti_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign out_valid        = (state_q == S_DONE);
  assign activation_value = act_q;
  assign tag_value        = tv_q;
  assign tag_index        = ti_q;

endmodule
